ttl_button_debounce_pulse: RTL and testbench

- Upstream stage for the TTL counter/display chain: conditions a raw mechanical pushbutton into a clean, single-cycle count-enable pulse.
- Its output drives the counter's CEP/CET enable, so each physical press advances the displayed digit exactly once.
- Contains a 2-FF synchronizer, a debounce timer, a 4-state FSM and an optional hold-to-auto-repeat generator.

---
 rtl/ttl_button_debounce_pulse.sv | 145 ++++++++++++++
 tb/tb_ttl_button_debounce_pulse.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ttl_button_debounce_pulse.sv
// ---------------------------------------------------------------------------
// ttl_button_debounce_pulse
//   Conditions a raw mechanical pushbutton into a clean debounced level and a
//   single-cycle count-enable pulse for the downstream TTL counter (CEP/CET).
//   Each accepted press gives one o_press pulse. While the button is held and
//   i_repeat_en is set, further o_press pulses follow after REPEAT_DELAY
//   cycles and then every REPEAT_PERIOD cycles.
//
// Ports
//   CP           in   clock, rising edge
//   rstn         in   asynchronous active-low reset
//   i_btn        in   raw asynchronous button level
//   i_repeat_en  in   auto-repeat enable while held (synchronous to CP)
//   o_level      out  debounced pressed level (1 = pressed)
//   o_press      out  1-cycle pulse on accepted press and on each repeat
//   o_release    out  1-cycle pulse on accepted release
//   o_state      out  FSM state for debug
//
// State | meaning
//   IDLE         (0) | released, waiting for a pressed sample
//   PRESS_WAIT   (1) | counting stable pressed samples
//   HELD         (2) | press accepted, optional auto-repeat running
//   RELEASE_WAIT (3) | counting stable released samples, level still high
// ---------------------------------------------------------------------------
module ttl_button_debounce_pulse #(
    parameter bit          ACTIVE_LOW_IN   = 1'b1,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000,
    parameter int unsigned CNT_W           = 26
) (
    input  logic       CP,
    input  logic       rstn,
    input  logic       i_btn,
    input  logic       i_repeat_en,
    output logic       o_level,
    output logic       o_press,
    output logic       o_release,
    output logic [1:0] o_state
);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RDLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPER_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q;
    logic [CNT_W-1:0] timer_q;
    logic [1:0]       sync_q;
    logic             rep_first_q;   // next repeat uses REPEAT_DELAY, not PERIOD
    logic             btn_pressed;
    logic             s;

    // Normalise so that 1 always means pressed before synchronising.
    assign btn_pressed = i_btn ^ ACTIVE_LOW_IN;
    assign s           = sync_q[1];
    assign o_state     = state_q;

    always_ff @(posedge CP or negedge rstn) begin
        if (!rstn) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_pressed};
        end
    end

    always_ff @(posedge CP or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            rep_first_q <= 1'b1;
            o_level     <= 1'b0;
            o_press     <= 1'b0;
            o_release   <= 1'b0;
        end else begin
            o_press   <= 1'b0;
            o_release <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    timer_q <= '0;
                    if (s) begin
                        state_q <= ST_PRESS_WAIT;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!s) begin
                        state_q <= ST_IDLE;
                        timer_q <= '0;
                    end else if (timer_q == DEB_LAST) begin
                        state_q     <= ST_HELD;
                        timer_q     <= '0;
                        rep_first_q <= 1'b1;
                        o_level     <= 1'b1;
                        o_press     <= 1'b1;
                    end else begin
                        timer_q <= timer_q + CNT_ONE;
                    end
                end
                ST_HELD: begin
                    if (!s) begin
                        state_q <= ST_RELEASE_WAIT;
                        timer_q <= '0;
                    end else if (!i_repeat_en) begin
                        // Disabled repeat parks the schedule at its start.
                        timer_q     <= '0;
                        rep_first_q <= 1'b1;
                    end else if (timer_q == (rep_first_q ? RDLY_LAST : RPER_LAST)) begin
                        timer_q     <= '0;
                        rep_first_q <= 1'b0;
                        o_press     <= 1'b1;
                    end else begin
                        timer_q <= timer_q + CNT_ONE;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (s) begin
                        // Release bounce: back to held, repeat schedule restarts.
                        state_q     <= ST_HELD;
                        timer_q     <= '0;
                        rep_first_q <= 1'b1;
                    end else if (timer_q == DEB_LAST) begin
                        state_q   <= ST_IDLE;
                        timer_q   <= '0;
                        o_level   <= 1'b0;
                        o_release <= 1'b1;
                    end else begin
                        timer_q <= timer_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    timer_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ttl_button_debounce_pulse.sv
// ---------------------------------------------------------------------------
// tb_ttl_button_debounce_pulse
//   Directed bench for ttl_button_debounce_pulse with DEBOUNCE_CYCLES=4,
//   REPEAT_DELAY=8, REPEAT_PERIOD=3, active-low button. Stimulus pushes the
//   expected pulse (kind + cycle) into a queue; a negedge monitor pops and
//   compares whenever o_press/o_release is seen and flags overdue entries.
//   Cycle numbering: cyc counts rising edges; an input driven at the negedge
//   where cyc==M is sampled on edge M+1, and a clean press/release shows its
//   pulse on edge M+1+DEBOUNCE+2 = M+7.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ttl_button_debounce_pulse;

    localparam int LAT = 7;

    logic       CP = 1'b0;
    logic       rstn = 1'b0;
    logic       i_btn = 1'b1;
    logic       i_repeat_en = 1'b0;
    logic       o_level;
    logic       o_press;
    logic       o_release;
    logic [1:0] o_state;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        bit rel;
        int at;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;

    ttl_button_debounce_pulse #(
        .ACTIVE_LOW_IN  (1'b1),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (8),
        .REPEAT_PERIOD  (3),
        .CNT_W          (8)
    ) dut (
        .CP         (CP),
        .rstn       (rstn),
        .i_btn      (i_btn),
        .i_repeat_en(i_repeat_en),
        .o_level    (o_level),
        .o_press    (o_press),
        .o_release  (o_release),
        .o_state    (o_state)
    );

    always #5 CP = ~CP;
    always @(posedge CP) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CP);
    endtask

    task automatic expect_ev(input bit rel, input int at);
        ev_t e;
        e.rel = rel;
        e.at  = at;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor
    always @(negedge CP) begin
        if (o_press || o_release) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: press=%0b release=%0b at cycle %0d, none expected",
                         o_press, o_release, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if ({o_press, o_release} != {~mon_e.rel, mon_e.rel} || mon_e.at != cyc) begin
                    n_fail++;
                    $display("FAIL pulse: got press=%0b release=%0b at cycle %0d, expected %s at cycle %0d",
                             o_press, o_release, cyc, mon_e.rel ? "release" : "press", mon_e.at);
                end
            end
        end
        while (exp_q.size() != 0 && exp_q[0].at < cyc) begin
            mon_e = exp_q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL missed_pulse: got nothing, expected %s at cycle %0d (now %0d)",
                     mon_e.rel ? "release" : "press", mon_e.at, cyc);
        end
    end

    initial begin
        int m;
        int t0;
        int p;

        // Reset values
        tick(1);
        check("rst_level", o_level, 0);
        check("rst_press", o_press, 0);
        check("rst_release", o_release, 0);
        check("rst_state", o_state, 0);
        tick(1);
        rstn = 1'b1;
        tick(3);

        // Clean press: state 0,0,1,...,1,2
        m = cyc;
        i_btn = 1'b0;
        expect_ev(1'b0, m + LAT);
        tick(1); check("p_state_e0", o_state, 0);
        tick(1); check("p_state_e1", o_state, 0);
        tick(1); check("p_state_e2", o_state, 1);
        tick(3); check("p_level_early", o_level, 0);
        check("p_state_e5", o_state, 1);
        tick(1); check("p_state_held", o_state, 2);
        check("p_level", o_level, 1);
        tick(3);

        // Release with one-sample glitch back to pressed
        m = cyc;
        i_btn = 1'b1;
        tick(2);
        i_btn = 1'b0;
        tick(1);
        i_btn = 1'b1;
        expect_ev(1'b1, m + 10);
        tick(1); check("r_state_rw", o_state, 3);
        check("r_level_rw", o_level, 1);
        tick(1); check("r_state_glitch", o_state, 2);
        check("r_level_glitch", o_level, 1);
        tick(1); check("r_state_rw2", o_state, 3);
        tick(4); check("r_state_idle", o_state, 0);
        check("r_level_idle", o_level, 0);
        tick(3);

        // Bounced press with auto-repeat enabled
        m = cyc;
        i_repeat_en = 1'b1;
        i_btn = 1'b0;
        tick(3);
        i_btn = 1'b1;
        tick(1);
        i_btn = 1'b0;
        t0 = m + 11;
        expect_ev(1'b0, t0);
        for (int k = 0; k < 8; k++) expect_ev(1'b0, t0 + 8 + 3 * k);
        tick(2); check("b_state_rejected", o_state, 0);
        tick(35);
        check("rep_level", o_level, 1);
        check("rep_state", o_state, 2);
        i_repeat_en = 1'b0;
        tick(15);

        // Re-enable: full delay again, then disable before the next period
        p = cyc;
        i_repeat_en = 1'b1;
        expect_ev(1'b0, p + 8);
        tick(9);
        i_repeat_en = 1'b0;
        tick(6);

        // Clean release
        m = cyc;
        i_btn = 1'b1;
        expect_ev(1'b1, m + LAT);
        tick(7);
        check("cr_state", o_state, 0);
        check("cr_level", o_level, 0);
        tick(3);

        // Asynchronous reset mid PRESS_WAIT, then full debounce
        i_btn = 1'b0;
        tick(5);
        check("ar_state_pw", o_state, 1);
        #2 rstn = 1'b0;
        #1;
        check("ar_state", o_state, 0);
        check("ar_level", o_level, 0);
        check("ar_press", o_press, 0);
        check("ar_release", o_release, 0);
        tick(2);
        m = cyc;
        rstn = 1'b1;
        expect_ev(1'b0, m + LAT);
        tick(6);
        check("ar_level_early", o_level, 0);
        check("ar_state_pw2", o_state, 1);
        tick(1);
        check("ar_level_held", o_level, 1);
        check("ar_state_held", o_state, 2);
        tick(3);

        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
